// File: rtl/tc_sram_req_adapter.sv
// Valid/ready request front-end for a single tc_sram port with credit-based read response buffering.
// Optional: define TC_SRAM_ADAPTER_WRITE_RSP_EN to make writes return a zero-data response.
module tc_sram_req_adapter #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned BufDepth  = 2,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntWidth = $clog2(BufDepth + 1);
  localparam int unsigned PtrWidth = (BufDepth > 1) ? $clog2(BufDepth) : 1;

  logic [CntWidth-1:0]  r_cnt;
  logic [CntWidth-1:0]  r_fill;
  logic [PtrWidth-1:0]  r_wptr;
  logic [PtrWidth-1:0]  r_rptr;
  logic [DataWidth-1:0] r_mem [BufDepth];
  logic [Latency-1:0]   r_tag;
  logic [Latency-1:0]   w_tag_next;
  logic                 w_credit_ok;
  logic                 w_track;
  logic                 w_accept;
  logic                 w_tag_in;
  logic                 w_push;
  logic                 w_pop;
  logic [DataWidth-1:0] w_push_data;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(BufDepth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign w_credit_ok = (r_cnt < CntWidth'(BufDepth));

`ifdef TC_SRAM_ADAPTER_WRITE_RSP_EN
  assign w_track     = 1'b1;
  assign req_ready_o = !rst_i && w_credit_ok;
`else
  assign w_track     = !req_we_i;
  assign req_ready_o = !rst_i && (req_we_i || w_credit_ok);
`endif

  assign w_accept = req_valid_i && req_ready_o;
  assign w_tag_in = w_accept && w_track;

  // SRAM strobes follow the handshake combinationally
  assign sram_req_o   = w_accept;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i & {BeWidth{req_we_i}};

  // Tag pipeline mirrors the SRAM read latency
  if (Latency == 1) begin : g_lat1
    assign w_tag_next = w_tag_in;
  end else begin : g_latn
    assign w_tag_next = {r_tag[Latency-2:0], w_tag_in};
  end

`ifdef TC_SRAM_ADAPTER_WRITE_RSP_EN
  logic [Latency-1:0] r_tag_we;
  logic [Latency-1:0] w_tag_we_next;

  if (Latency == 1) begin : g_we_lat1
    assign w_tag_we_next = w_accept && req_we_i;
  end else begin : g_we_latn
    assign w_tag_we_next = {r_tag_we[Latency-2:0], w_accept && req_we_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_tag_we <= '0;
    else       r_tag_we <= w_tag_we_next;
  end

  assign w_push_data = r_tag_we[Latency-1] ? '0 : sram_rdata_i;
`else
  assign w_push_data = sram_rdata_i;
`endif

  assign w_push      = r_tag[Latency-1];
  assign rsp_valid_o = (r_fill != '0);
  assign w_pop       = rsp_valid_o && rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? r_mem[r_rptr] : '0;

  // Credits, occupancy, pointers and tag pipeline
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_fill <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_tag  <= '0;
    end else begin
      r_tag <= w_tag_next;
      if (w_tag_in && !w_pop)      r_cnt <= r_cnt + CntWidth'(1);
      else if (!w_tag_in && w_pop) r_cnt <= r_cnt - CntWidth'(1);
      if (w_push && !w_pop)        r_fill <= r_fill + CntWidth'(1);
      else if (!w_push && w_pop)   r_fill <= r_fill - CntWidth'(1);
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
    end
  end

  // Response storage needs no reset; the output is gated by occupancy
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

endmodule

// File: tb/tb_tc_sram_req_adapter.sv
// Scoreboard bench for tc_sram_req_adapter: instance A (Latency 1, BufDepth 2) and
// instance B (Latency 2, BufDepth 4) each driving a behavioural SRAM model.
module tb_tc_sram_req_adapter;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 10;
  localparam int unsigned BW = 8;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic          a_valid, a_ready, a_we, a_rsp_valid, a_rsp_ready, a_sreq, a_swe;
  logic [AW-1:0] a_addr, a_saddr;
  logic [DW-1:0] a_wdata, a_rsp_rdata, a_swdata, a_rd;
  logic [BW-1:0] a_be, a_sbe;
  logic          b_valid, b_ready, b_we, b_rsp_valid, b_rsp_ready, b_sreq, b_swe;
  logic [AW-1:0] b_addr, b_saddr;
  logic [DW-1:0] b_wdata, b_rsp_rdata, b_swdata, b_rd0, b_rd1;
  logic [BW-1:0] b_be, b_sbe;

  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];
  int a_rsp_cnt = 0;
  int b_rsp_cnt = 0;
  int b_first = 0;
  int b_last = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tc_sram_req_adapter #(.NumWords(1024), .DataWidth(64), .ByteWidth(8), .Latency(1), .BufDepth(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(a_valid), .req_ready_o(a_ready), .req_we_i(a_we),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata), .req_be_i(a_be), .rsp_valid_o(a_rsp_valid),
    .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata), .sram_req_o(a_sreq), .sram_we_o(a_swe),
    .sram_addr_o(a_saddr), .sram_wdata_o(a_swdata), .sram_be_o(a_sbe), .sram_rdata_i(a_rd));

  tc_sram_req_adapter #(.NumWords(1024), .DataWidth(64), .ByteWidth(8), .Latency(2), .BufDepth(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(b_we),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata), .req_be_i(b_be), .rsp_valid_o(b_rsp_valid),
    .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata), .sram_req_o(b_sreq), .sram_we_o(b_swe),
    .sram_addr_o(b_saddr), .sram_wdata_o(b_swdata), .sram_be_o(b_sbe), .sram_rdata_i(b_rd1));

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {22'h3A5A5A, a, 22'h155555, a};
  endfunction

  // Latency-1 SRAM model with byte-enable writes
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= pat(AW'(i));
    end else if (a_sreq) begin
      if (a_swe) begin
        for (int b = 0; b < 8; b++) if (a_sbe[b]) mem_a[a_saddr][b*8 +: 8] <= a_swdata[b*8 +: 8];
      end else begin
        a_rd <= mem_a[a_saddr];
      end
    end
  end

  // Latency-2 SRAM model (read only in this bench)
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= pat(AW'(i));
    end else if (b_sreq && !b_swe) begin
      b_rd0 <= mem_b[b_saddr];
    end
    b_rd1 <= b_rd0;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && a_rsp_valid && a_rsp_ready) begin
      a_rsp_cnt++;
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_rsp: got data %h, expected no response", a_rsp_rdata);
      end else begin
        chk("a_rsp_data", a_rsp_rdata, exp_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_rsp_valid && b_rsp_ready) begin
      if (b_rsp_cnt == 0) b_first = cyc;
      b_last = cyc;
      b_rsp_cnt++;
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_rsp: got data %h, expected no response", b_rsp_rdata);
      end else begin
        chk("b_rsp_data", b_rsp_rdata, exp_b.pop_front());
      end
    end
  end

  // One request on A; entered and left just after a rising edge
  task automatic a_xfer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be, input logic [DW-1:0] exp);
    bit ok = 1'b0;
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (a_ready) begin
        ok = 1'b1;
        chk("a_sram_req", 64'(a_sreq), 64'd1);
        chk("a_sram_be", 64'(a_sbe), we ? 64'(be) : 64'd0);
        if (!we) exp_a.push_back(exp);
`ifdef TC_SRAM_ADAPTER_WRITE_RSP_EN
        if (we) exp_a.push_back('0);
`endif
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL a_xfer_timeout: request at addr %0d never accepted, expected acceptance", addr);
    end
  endtask

  // Stream reads into A with the consumer stalled for the first `stall` cycles
  task automatic a_burst(input logic [AW-1:0] base, input int n, input int stall);
    int idx = 0;
    int k = 0;
    a_rsp_ready = 1'b0;
    a_we = 1'b0;
    a_be = '0;
    while (idx < n && k < stall + 40) begin
      if (k == stall) begin
        chk("a_stall_accepts", 64'(idx), 64'd2);
        chk("a_stall_ready", 64'(a_ready), 64'd0);
        a_rsp_ready = 1'b1;
      end
      a_valid = 1'b1;
      a_addr = base + AW'(idx);
      @(negedge clk);
      if (a_ready) begin
        exp_a.push_back(pat(a_addr));
        idx++;
      end
      @(posedge clk); #1;
      k++;
    end
    a_valid = 1'b0;
    a_rsp_ready = 1'b1;
    chk("a_burst_accepted", 64'(idx), 64'(n));
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && (exp_a.size() != 0 || exp_b.size() != 0); k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int base_cnt;
    rst = 1'b1; preload = 1'b1;
    a_valid = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0; a_rsp_ready = 1'b1;
    b_valid = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0; b_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_a_sram_req", 64'(a_sreq), 64'd0);
    chk("rst_b_sram_req", 64'(b_sreq), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("idle_a_ready", 64'(a_ready), 64'd1);
    chk("idle_a_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("idle_a_rsp_rdata", a_rsp_rdata, 64'd0);
    chk("idle_a_sram_req", 64'(a_sreq), 64'd0);
    chk("idle_b_ready", 64'(b_ready), 64'd1);
    @(posedge clk); #1;

    // Write then read back with latency check
    a_xfer(1'b1, AW'(5), 64'hDEAD_BEEF, 8'hFF, '0);
    repeat (3) @(posedge clk);
    #1;
    a_xfer(1'b0, AW'(5), '0, 8'hFF, 64'hDEAD_BEEF);
    @(negedge clk);
    chk("a_lat_t1_valid", 64'(a_rsp_valid), 64'd0);
    @(negedge clk);
    chk("a_lat_t2_valid", 64'(a_rsp_valid), 64'd1);
    @(posedge clk); #1;
    wait_drain();
`ifdef TC_SRAM_ADAPTER_WRITE_RSP_EN
    chk("a_rsp_count_wr_rd", 64'(a_rsp_cnt), 64'd2);
`else
    chk("a_rsp_count_wr_rd", 64'(a_rsp_cnt), 64'd1);
`endif

    // Back-to-back reads; credit spans Latency+1 cycles so BufDepth 4 sustains Latency 2
    for (int i = 0; i < 10; i++) begin
      b_valid = 1'b1;
      b_addr = AW'(40 + i);
      @(negedge clk);
      chk("b_ready_stream", 64'(b_ready), 64'd1);
      if (b_ready) exp_b.push_back(pat(b_addr));
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    for (int k = 0; k < 30 && b_rsp_cnt < 10; k++) begin
      @(posedge clk); #1;
    end
    chk("b_rsp_count", 64'(b_rsp_cnt), 64'd10);
    chk("b_rsp_span", 64'(b_last - b_first), 64'd9);

    // Stalled consumer: two credits, then drain and accept the rest
    a_burst(AW'(10), 4, 6);
    wait_drain();

    // Partial byte-enable write
    a_xfer(1'b1, AW'(20), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, '0);
    a_xfer(1'b1, AW'(20), 64'h0000_0000_0000_0011, 8'h01, '0);
    a_xfer(1'b0, AW'(20), '0, 8'hFF, 64'hFFFF_FFFF_FFFF_FF11);
    wait_drain();

    // Reset with two reads in flight
    a_rsp_ready = 1'b0;
    a_xfer(1'b0, AW'(30), '0, '0, pat(AW'(30)));
    a_xfer(1'b0, AW'(31), '0, '0, pat(AW'(31)));
    rst = 1'b1;
    exp_a.delete();
    @(negedge clk);
    chk("rst_mid_a_ready", 64'(a_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    base_cnt = a_rsp_cnt;
    a_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
      @(posedge clk); #1;
    end
    chk("post_rst_rsp_count", 64'(a_rsp_cnt), 64'(base_cnt));
    a_burst(AW'(32), 3, 4);
    wait_drain();

    // Lone write: response only when write responses are enabled
    base_cnt = a_rsp_cnt;
    a_xfer(1'b1, AW'(50), 64'h1234, 8'hFF, '0);
    repeat (5) @(posedge clk);
    #1;
`ifdef TC_SRAM_ADAPTER_WRITE_RSP_EN
    chk("write_rsp_count", 64'(a_rsp_cnt - base_cnt), 64'd1);
`else
    chk("write_rsp_count", 64'(a_rsp_cnt - base_cnt), 64'd0);
`endif

    wait_drain();
    chk("a_queue_empty", 64'(exp_a.size()), 64'd0);
    chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
